pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the ARM core. It drives the IF/IF_Stage_Reg `freeze` and `flush` controls and the ID-stage bubble insert. To do this it tracks in-flight destination registers (EX/MEM scoreboard), detects RAW hazards, converts EX-stage branch resolution into flush, and holds the whole pipe during multi-cycle data-memory (SRAM) handshakes. It sits beside the stage chain in the ARM top and replaces the constant-0 freeze/flush/branch tie-offs.

Parameters:
- REG_ADDR_LEN, 4, register-file index width.
- FWD_EN, 0, 1 = forwarding present, so only load-use hazards stall.
- MEM_TIMEOUT, 64, max WAIT cycles before the error trap.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- id_src1  in  REG_ADDR_LEN  ID operand Rn.
- id_src2  in  REG_ADDR_LEN  ID operand Rm/Rd (store).
- id_two_src  in  1  id_src2 is read.
- id_valid  in  1  ID holds a real, non-bubble instruction.
- id_dest  in  REG_ADDR_LEN  ID destination.
- id_wb_en  in  1  ID instruction writes back.
- id_mem_read  in  1  ID instruction is a load.
- branch_taken  in  1  EX resolved a taken branch.
- mem_req  in  1  MEM stage requests a data access.
- mem_ready  in  1  SRAM completes the access this cycle.
- freeze  out  1  hold PC, IF_Stage_Reg and ID.
- bubble  out  1  ID_Stage_Reg loads a NOP.
- flush  out  1  clear IF_Stage_Reg and ID_Stage_Reg.
- mem_freeze  out  1  hold all stage registers.
- mem_err  out  1  sticky memory timeout.
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst=0, async): scoreboard entries invalid, FSM=IDLE, mem_err=0, stall_cycles=0. All outputs 0.
- Scoreboard holds two registered entries, EX and MEM, each {valid, dest, wb_en, mem_read}.
  - Advances on every clk edge where mem_freeze=0: MEM<=EX.
  - EX<=ID fields if id_valid & ~hazard & ~flush, else EX<=invalid.
  - When mem_freeze=1, both entries hold.
- RAW match is combinational: (id_src1==E.dest) | (id_two_src & id_src2==E.dest), for a valid entry E with wb_en.
  - FWD_EN=0: hazard = match(EX) | match(MEM).
  - FWD_EN=1: hazard = match(EX) & EX.mem_read.
  - hazard is forced to 0 when id_valid=0.
- freeze = hazard | mem_freeze. bubble = hazard & ~mem_freeze & ~flush.
- flush = branch_taken & ~mem_freeze.
  - Branch wins over hazard: when flush=1, freeze is driven only by mem_freeze.
  - While mem_freeze=1, flush is deferred; EX holds the branch, so branch_taken persists.
- Memory FSM states: IDLE, WAIT, ERR.
  - IDLE: mem_req & ~mem_ready -> WAIT, wait counter cleared. mem_req & mem_ready (single-cycle access) stays IDLE.
  - WAIT: mem_ready -> IDLE. Counter increments each cycle; reaching MEM_TIMEOUT-1 without mem_ready -> ERR.
  - ERR: mem_err=1, mem_freeze=1 permanently. Exit only by reset.
  - mem_freeze (combinational) = (IDLE & mem_req & ~mem_ready) | (WAIT & ~mem_ready) | ERR.
  - mem_ready is ignored in IDLE when mem_req=0.
- stall_cycles increments on each cycle with bubble=1 and saturates at all-ones. Counts only load-use/RAW stalls, not memory stalls.
- Latency: hazard, freeze and flush are same-cycle combinational from ID/EX inputs plus registered state. Scoreboard and FSM update on the next edge.
- Reset asserted mid-WAIT or in ERR returns immediately to IDLE with all outputs 0.

Decomposition:
- The shared configs/package holds REG_ADDR_LEN, the FSM state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2) and the scoreboard-entry field widths.
- One natural sub-module is `mem_wait_fsm`: FSM, timeout counter, mem_freeze and mem_err.
- Scoreboard and hazard compare stay in the parent.

Test Plan:
- FWD_EN=0: ADD r1 (id_wb_en) then SUB reading r1 next cycle -> freeze=1, bubble=1 for 2 cycles, then issue. stall_cycles=2.
- FWD_EN=1: LDR r3 then ADD reading r3 -> exactly 1 stall cycle. Non-load producer -> 0 stalls.
- branch_taken=1 in the same cycle as an RAW hazard -> flush=1, freeze=0, bubble=0. The next EX entry is invalid.
- mem_req with mem_ready after 5 cycles while branch_taken=1 -> mem_freeze=1 for 5 cycles and flush=0 throughout. flush=1 on the cycle mem_ready rises; scoreboard unchanged during the hold.
- MEM_TIMEOUT=8, mem_ready never asserted -> ERR after 8 WAIT cycles, mem_err=1 and freeze=1 sticky. Asserting rst low mid-ERR clears all outputs asynchronously.
- stall_cycles with CNT_W=4 driven through 20 stalls -> reads 15 (saturated).

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared widths, state encoding and scoreboard-entry layout for the
// pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  // Register-file index width (default for the controller parameter).
  localparam int REG_ADDR_LEN = 4;

  // Scoreboard entry field widths: {valid, dest, wb_en, mem_read}.
  localparam int SB_FLAG_W = 1;
  localparam int SB_DEST_W = REG_ADDR_LEN;

  // Data-memory handshake FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait sequencer: holds the pipe while the SRAM is busy and
// traps into a sticky error state when the access never completes.
module mem_wait_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_freeze,
  output logic mem_err
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST_CNT = TW'(MEM_TIMEOUT - 1);

  mem_state_e    state_q;
  logic [TW-1:0] wait_cnt_q;
  logic          mem_err_q;

  // State, timeout counter and sticky error flag; an unknown state traps to ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_req && !mem_ready) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            state_q <= ST_IDLE;
          end else if (wait_cnt_q == LAST_CNT) begin
            state_q   <= ST_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end
        ST_ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_ERR;
          mem_err_q <= 1'b1;
        end
      endcase
    end
  end

  // Hold the pipe while an access is outstanding or the memory has failed.
  always_comb begin
    mem_freeze = 1'b0;
    case (state_q)
      ST_IDLE: mem_freeze = mem_req & ~mem_ready;
      ST_WAIT: mem_freeze = ~mem_ready;
      ST_ERR:  mem_freeze = 1'b1;
      default: mem_freeze = 1'b1;
    endcase
  end

  assign mem_err = mem_err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: EX/MEM destination scoreboard, RAW hazard
// detection, branch flush and memory-wait hold for the ARM stage chain.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_LEN = pipeline_hazard_ctrl_pkg::REG_ADDR_LEN,
  parameter bit FWD_EN       = 1'b0,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_two_src,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_read,
  input  logic                    branch_taken,
  input  logic                    mem_req,
  input  logic                    mem_ready,
  output logic                    freeze,
  output logic                    bubble,
  output logic                    flush,
  output logic                    mem_freeze,
  output logic                    mem_err,
  output logic [CNT_W-1:0]        stall_cycles
);

  import pipeline_hazard_ctrl_pkg::*;

  typedef struct packed {
    logic [SB_FLAG_W-1:0]    valid;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [SB_FLAG_W-1:0]    wb_en;
    logic [SB_FLAG_W-1:0]    mem_read;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  sb_entry_t        ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             hazard_s, match_ex_s, match_mem_s;
  logic             mem_freeze_s, flush_s, bubble_s;

  // True when the ID operands read the destination of a live writer.
  function automatic logic raw_match(input sb_entry_t e,
                                     input logic [REG_ADDR_LEN-1:0] s1,
                                     input logic [REG_ADDR_LEN-1:0] s2,
                                     input logic two_src);
    return e.valid[0] & e.wb_en[0] & ((s1 == e.dest) | (two_src & (s2 == e.dest)));
  endfunction

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_freeze (mem_freeze_s),
    .mem_err    (mem_err)
  );

  // Hazard detection and stage controls; a taken branch overrides the stall.
  always_comb begin
    match_ex_s  = raw_match(ex_q, id_src1, id_src2, id_two_src);
    match_mem_s = raw_match(mem_q, id_src1, id_src2, id_two_src);
    if (FWD_EN) begin
      hazard_s = id_valid & match_ex_s & ex_q.mem_read[0];
    end else begin
      hazard_s = id_valid & (match_ex_s | match_mem_s);
    end
    flush_s  = branch_taken & ~mem_freeze_s;
    bubble_s = hazard_s & ~mem_freeze_s & ~flush_s;
  end

  // Scoreboard next state: shift EX into MEM, admit ID only when it issues.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!mem_freeze_s) begin
      mem_d = ex_q;
      if (id_valid && !hazard_s && !flush_s) begin
        ex_d = '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};
      end else begin
        ex_d = SB_EMPTY;
      end
    end else begin
      ex_d  = ex_q;
      mem_d = mem_q;
    end
  end

  // Saturating count of hazard-bubble cycles.
  always_comb begin
    if (bubble_s && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Scoreboard and stall-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q    <= SB_EMPTY;
      mem_q   <= SB_EMPTY;
      stall_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      stall_q <= stall_d;
    end
  end

  assign flush        = flush_s;
  assign bubble       = bubble_s;
  assign freeze       = (hazard_s & ~flush_s) | mem_freeze_s;
  assign mem_freeze   = mem_freeze_s;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a no-forwarding instance with a
// short timeout and narrow counter, plus a forwarding instance, on shared inputs.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
    logic [3:0] dest;
    logic       wb;
    logic       mr;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } in_t;

  // exp = {freeze, bubble, flush, mem_freeze} of the no-forwarding instance
  typedef struct packed {
    in_t        in;
    logic [3:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] id_src1 = 4'd0, id_src2 = 4'd0, id_dest = 4'd0;
  logic       id_two_src = 1'b0, id_valid = 1'b0, id_wb_en = 1'b0, id_mem_read = 1'b0;
  logic       branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic        f0, b0, fl0, mf0, me0;
  logic [3:0]  sc0;
  logic        f1, b1, fl1, mf1, me1;
  logic [15:0] sc1;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_LEN(4), .FWD_EN(1'b0), .MEM_TIMEOUT(8), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze(f0), .bubble(b0), .flush(fl0), .mem_freeze(mf0), .mem_err(me0), .stall_cycles(sc0)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_LEN(4), .FWD_EN(1'b1), .MEM_TIMEOUT(64), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze(f1), .bubble(b1), .flush(fl1), .mem_freeze(mf1), .mem_err(me1), .stall_cycles(sc1)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                             input logic two, input logic [3:0] d, input logic wb,
                             input logic mr, input logic br, input logic mreq,
                             input logic mrdy);
    in_t r;
    r = '{valid: v, src1: s1, src2: s2, two: two, dest: d, wb: wb, mr: mr,
          br: br, mreq: mreq, mrdy: mrdy};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic apply(input in_t v);
    @(posedge clk);
    #1;
    id_valid = v.valid; id_src1 = v.src1; id_src2 = v.src2; id_two_src = v.two;
    id_dest = v.dest; id_wb_en = v.wb; id_mem_read = v.mr; branch_taken = v.br;
    mem_req = v.mreq; mem_ready = v.mrdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    id_valid = 1'b0; id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_dest = 4'd0;
    id_wb_en = 1'b0; id_mem_read = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  vec_t tbl[11];
  in_t  idle_in;

  initial begin
    idle_in = mk(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // RAW stalls without forwarding, two_src/id_valid qualifiers, branch priority
    tbl[0]  = '{in: mk(1, 4'd2, 4'd3, 1, 4'd1, 1, 0, 0, 0, 0),  exp: 4'b0000};
    tbl[1]  = '{in: mk(1, 4'd1, 4'd4, 1, 4'd5, 1, 0, 0, 0, 0),  exp: 4'b1100};
    tbl[2]  = '{in: mk(1, 4'd1, 4'd4, 1, 4'd5, 1, 0, 0, 0, 0),  exp: 4'b1100};
    tbl[3]  = '{in: mk(1, 4'd1, 4'd4, 1, 4'd5, 1, 0, 0, 0, 0),  exp: 4'b0000};
    tbl[4]  = '{in: mk(1, 4'd6, 4'd5, 0, 4'd7, 1, 0, 0, 0, 0),  exp: 4'b0000};
    tbl[5]  = '{in: mk(0, 4'd7, 4'd7, 1, 4'd9, 1, 0, 0, 0, 0),  exp: 4'b0000};
    tbl[6]  = '{in: mk(1, 4'd0, 4'd7, 1, 4'd8, 0, 0, 0, 0, 0),  exp: 4'b1100};
    tbl[7]  = '{in: mk(1, 4'd0, 4'd7, 1, 4'd8, 0, 0, 0, 0, 0),  exp: 4'b0000};
    tbl[8]  = '{in: mk(1, 4'd8, 4'd8, 1, 4'd9, 1, 0, 0, 0, 0),  exp: 4'b0000};
    tbl[9]  = '{in: mk(1, 4'd9, 4'd0, 0, 4'd10, 1, 0, 1, 0, 0), exp: 4'b0010};
    tbl[10] = '{in: mk(1, 4'd10, 4'd0, 0, 4'd11, 1, 0, 0, 0, 0), exp: 4'b0000};

    // Reset state
    #2;
    chk("rst_out0", {27'd0, f0, b0, fl0, mf0, me0}, 32'd0);
    chk("rst_out1", {27'd0, f1, b1, fl1, mf1, me1}, 32'd0);
    chk("rst_cnt0", 32'(sc0), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].in);
      chk($sformatf("vec%0d", i), {28'd0, f0, b0, fl0, mf0}, {28'd0, tbl[i].exp});
    end
    chk("vec_stall_cnt", 32'(sc0), 32'd3);

    // Forwarding: load-use stalls one cycle, ALU producer does not stall
    do_reset();
    apply(mk(1, 4'd0, 4'd0, 0, 4'd3, 1, 1, 0, 0, 0));
    chk("fwd_ldr", {30'd0, f1, b1}, 32'd0);
    apply(mk(1, 4'd3, 4'd0, 0, 4'd4, 1, 0, 0, 0, 0));
    chk("fwd_loaduse", {30'd0, f1, b1}, 32'b11);
    apply(mk(1, 4'd3, 4'd0, 0, 4'd4, 1, 0, 0, 0, 0));
    chk("fwd_issue", {30'd0, f1, b1}, 32'd0);
    apply(mk(1, 4'd4, 4'd0, 0, 4'd5, 1, 0, 0, 0, 0));
    chk("fwd_alu_nostall", {30'd0, f1, b1}, 32'd0);
    chk("fwd_stall_cnt", 32'(sc1), 32'd1);

    // Memory hold with a pending branch: flush deferred, scoreboard frozen
    do_reset();
    apply(mk(1, 4'd0, 4'd0, 0, 4'd6, 1, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      apply(mk(1, 4'd12, 4'd0, 0, 4'd13, 1, 0, 1, 1, 0));
      chk($sformatf("memhold%0d", k), {28'd0, f0, b0, fl0, mf0}, 32'b1001);
    end
    apply(mk(1, 4'd12, 4'd0, 0, 4'd13, 1, 0, 1, 1, 1));
    chk("memhold_release", {28'd0, f0, b0, fl0, mf0}, 32'b0010);
    apply(mk(1, 4'd6, 4'd0, 0, 4'd14, 1, 0, 0, 0, 0));
    chk("memhold_sb_kept", {28'd0, f0, b0, fl0, mf0}, 32'b1100);
    apply(idle_in);
    chk("memhold_stall_cnt", 32'(sc0), 32'd1);

    // Timeout trap, stickiness, asynchronous reset out of ERR
    do_reset();
    for (int k = 0; k < 9; k++) begin
      apply(mk(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 1, 0));
      chk($sformatf("to_wait%0d", k), {30'd0, mf0, me0}, 32'b10);
    end
    apply(mk(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 1, 0));
    chk("to_err", {29'd0, f0, mf0, me0}, 32'b111);
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 1));
      chk($sformatf("err_sticky%0d", k), {29'd0, f0, fl0, me0}, 32'b101);
    end
    branch_taken = 1'b0; mem_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("err_async_rst", {27'd0, f0, b0, fl0, mf0, me0}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Counter saturation: 20 bubbles into a 4-bit counter
    do_reset();
    for (int it = 0; it < 10; it++) begin
      apply(mk(1, 4'd0, 4'd0, 0, 4'd1, 1, 0, 0, 0, 0));
      apply(mk(1, 4'd1, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0));
      apply(mk(1, 4'd1, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0));
      apply(mk(1, 4'd1, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0));
      if (it == 6) chk("sat_mid", 32'(sc0), 32'd14);
    end
    chk("sat_final", 32'(sc0), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
